// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Owns the PC and the instruction register and publishes the state code
// (estado) for the downstream control-signal generator.
// Optional build macro SEQ_TIMEOUT_EN adds a fetch timeout that halts the
// sequencer and raises err after TIMEOUT_CYC unacknowledged request cycles.
module instr_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        dmem_done,
  input  logic        branch_taken,
  output logic [3:0]  estado,
  output logic [2:0]  tipo,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        halted
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [3:0] {
    FETCH  = 4'b0000,
    DECODE = 4'b0001,
    EXEC   = 4'b0010,
    MEM    = 4'b0100,
    WB     = 4'b1111,
    HALT   = 4'b1000
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state;
  logic [31:0] ir;

  // Branch displacement: 13-bit B-type immediate, sign-extended to 32 bits.
  function automatic logic signed [31:0] branch_off(input logic [31:0] w);
    branch_off = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  // Only these four major opcodes are executed; anything else halts.
  function automatic logic opcode_legal(input logic [6:0] op);
    opcode_legal = (op == 7'b0010011) || (op == 7'b0000011) ||
                   (op == 7'b0110011) || (op == 7'b1100011);
  endfunction

  // Requests follow run combinationally so an ack can land on the first
  // FETCH cycle; reset forces the request low even while run is high.
  assign imem_req  = rst_n && run && (state == FETCH);
  assign imem_addr = pc;
  assign estado    = state;
  assign halted    = (state == HALT);
  assign instr     = ir;
  assign tipo      = ir[6:4];
  assign funct3    = ir[14:12];
  assign funct7    = ir[31:25];

`ifdef SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

  // Sequencer FSM with PC and IR state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= NOP;
`ifdef SEQ_TIMEOUT_EN
      cnt   <= '0;
      err   <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (imem_req && imem_ack) begin
            ir    <= imem_rdata;
            state <= DECODE;
`ifdef SEQ_TIMEOUT_EN
            cnt   <= '0;
`endif
          end
`ifdef SEQ_TIMEOUT_EN
          else if (imem_req) begin
            if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
              state <= HALT;
              err   <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
        end
        DECODE: state <= opcode_legal(ir[6:0]) ? EXEC : HALT;
        EXEC:   state <= (ir[6:4] == 3'b000) ? MEM : WB;
        MEM:    if (dmem_done) state <= WB;
        WB: begin
          if (ir[6:4] == 3'b110 && branch_taken) pc <= pc + branch_off(ir);
          else                                   pc <= pc + 32'd4;
          state <= FETCH;
        end
        HALT:    state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus a random
// instruction stream checked against a per-instruction reference model.
module tb_instr_sequencer;

  localparam logic [3:0] S_FETCH = 4'b0000, S_DEC = 4'b0001, S_EXEC = 4'b0010,
                         S_MEM = 4'b0100, S_WB = 4'b1111, S_HALT = 4'b1000;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dmem_done = 1'b0;
  logic        branch_taken = 1'b0;
  logic        imem_req, halted;
  logic [31:0] imem_addr, instr, pc;
  logic [3:0]  estado;
  logic [2:0]  tipo, funct3;
  logic [6:0]  funct7;
`ifdef SEQ_TIMEOUT_EN
  logic        err;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ir;

  instr_sequencer #(.RESET_PC(RST_PC), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_done(dmem_done), .branch_taken(branch_taken),
    .estado(estado), .tipo(tipo), .funct3(funct3), .funct7(funct7),
    .instr(instr), .pc(pc), .halted(halted)
`ifdef SEQ_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // B-type displacement computed from the bit weights of the encoding.
  function automatic logic [31:0] boff(input logic [31:0] w);
    int off;
    off = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    return 32'(off);
  endfunction

  function automatic logic [31:0] enc_branch(input int off);
    logic [12:0] imm;
    imm = off[12:0];
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op == 7'b0010011 || op == 7'b0000011 || op == 7'b0110011 || op == 7'b1100011;
  endfunction

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_estado", estado, S_FETCH);
    chk("rst_pc", pc, RST_PC);
    chk("rst_ir", instr, 32'h0000_0013);
    chk("rst_req", imem_req, 0);
    chk("rst_halted", halted, 0);
`ifdef SEQ_TIMEOUT_EN
    chk("rst_err", err, 0);
`endif
    run = 1'b0; imem_ack = 1'b0; dmem_done = 1'b0;
    step();
    rst_n = 1'b1;
    m_pc = RST_PC;
    m_ir = 32'h0000_0013;
    step();
    chk("post_rst_state", estado, S_FETCH);
    chk("post_rst_req", imem_req, 0);
  endtask

  // One instruction from the idle FETCH state; expected path derived from
  // the opcode class: legal non-load 4 states, load adds MEM, illegal halts.
  task automatic do_instr(input logic [31:0] w, input int ack_dly, input int mem_dly,
                          input logic bt, input logic drop_run);
    logic [31:0] exp_pc;
    chk("idle_state", estado, S_FETCH);
    run = 1'b1;
    #1;
    chk("req_on_run", imem_req, 1);
    chk("imem_addr", imem_addr, m_pc);
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack = 1'b0; imem_rdata = $urandom; branch_taken = 1'($urandom);
      step();
      chk("fetch_wait", estado, S_FETCH);
      chk("ir_hold", instr, m_ir);
    end
    imem_ack = 1'b1; imem_rdata = w;
    step();
    imem_ack = 1'b0; imem_rdata = $urandom;
    if (drop_run) run = 1'b0;
    m_ir = w;
    chk("decode", estado, S_DEC);
    chk("ir_load", instr, w);
    chk("tipo", tipo, w[6:4]);
    chk("funct3", funct3, w[14:12]);
    chk("funct7", funct7, w[31:25]);
    if (!legal(w[6:0])) begin
      step();
      chk("halt_state", estado, S_HALT);
      chk("halted", halted, 1);
      for (int i = 0; i < 3; i++) begin
        run = 1'b1; imem_ack = 1'b1; imem_rdata = $urandom;
        #1 chk("halt_req", imem_req, 0);
        step();
        chk("halt_stay", estado, S_HALT);
        chk("halt_pc", pc, m_pc);
        chk("halt_ir", instr, w);
      end
      imem_ack = 1'b0;
      return;
    end
    branch_taken = 1'($urandom);
    step();
    chk("exec", estado, S_EXEC);
    step();
    if (w[6:4] == 3'b000) begin
      chk("mem", estado, S_MEM);
      for (int j = 0; j < mem_dly; j++) begin
        dmem_done = 1'b0;
        step();
        chk("mem_hold", estado, S_MEM);
      end
      dmem_done = 1'b1;
      step();
      dmem_done = 1'b0;
    end
    chk("wb", estado, S_WB);
    branch_taken = bt;
    exp_pc = (w[6:4] == 3'b110 && bt) ? m_pc + boff(w) : m_pc + 32'd4;
    step();
    branch_taken = 1'b0;
    chk("back_fetch", estado, S_FETCH);
    chk("pc_update", pc, exp_pc);
    m_pc = exp_pc;
    if (drop_run) begin
      chk("idle_req", imem_req, 0);
      imem_ack = 1'b1; imem_rdata = $urandom;
      step();
      imem_ack = 1'b0;
      chk("ack_ignored_state", estado, S_FETCH);
      chk("ack_ignored_ir", instr, w);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [6:0]  opc [4] = '{7'b0010011, 7'b0000011, 7'b0110011, 7'b1100011};
    m_pc = RST_PC;
    m_ir = 32'h0000_0013;
    run = 1'b1;
    #1;
    chk("init_req", imem_req, 0);
    chk("init_pc", pc, RST_PC);
    run = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    do_instr(32'h00500093, 0, 0, 1'b0, 1'b0);          // addi: pc 0 -> 4
    do_instr(32'h00000463, 0, 0, 1'b1, 1'b0);          // beq taken +8
    do_instr(32'h00000463, 0, 0, 1'b0, 1'b0);          // beq not taken
    do_instr(32'h00008083, 0, 3, 1'b1, 1'b0);          // lb, done delayed
    do_instr(32'h00008083, 2, 0, 1'b0, 1'b1);          // lb, run dropped mid-instr
    do_instr(32'h002081b3, 1, 0, 1'b1, 1'b1);          // R-type

    for (int k = 0; k < 80; k++) begin
      r = $urandom;
      do_instr({r[31:7], opc[$urandom_range(0, 3)]}, $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    // Wrap-around: branch -4 from 0 lands on FFFFFFFC, then +4 wraps to 0.
    do_reset();
    do_instr(enc_branch(-4), 0, 0, 1'b1, 1'b0);
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    do_instr(32'h00500093, 0, 0, 1'b0, 1'b0);
    chk("wrap_post", pc, 32'h0000_0000);

    // Reset while stalled in MEM discards the load.
    do_instr(32'h00500093, 0, 0, 1'b0, 1'b0);
    run = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h00008083;
    step();
    imem_ack = 1'b0;
    step();
    step();
    step();
    chk("stall_mem", estado, S_MEM);
    do_reset();

`ifdef SEQ_TIMEOUT_EN
    do_instr(32'h00500093, 15, 0, 1'b0, 1'b0);
    chk("late_ack_err", err, 0);
    run = 1'b1; imem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to_wait", estado, S_FETCH);
    end
    step();
    chk("to_halt", estado, S_HALT);
    chk("to_err", err, 1);
    chk("to_halted", halted, 1);
    do_reset();
`else
    run = 1'b1; imem_ack = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("wait_forever", estado, S_FETCH);
    chk("wait_req", imem_req, 1);
    run = 1'b0;
    step();
`endif

    // Illegal opcode halts with PC frozen; reset recovers.
    do_instr(32'h00500093, 0, 0, 1'b0, 1'b0);
    do_instr(32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0);
    chk("illegal_pc", pc, 32'h0000_0004);
    do_reset();
    chk("recover_pc", pc, RST_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
